frame_packer: RTL and testbench

Transmit-side counterpart of the frame unpacker. Accepts one parsed message (2-bit type plus a fixed-length payload) through a valid/ready handshake and serialises it into the byte-stream frame format the unpacker consumes: start byte 0x7E, then the type byte, then PAYLOAD_LEN payload bytes, most significant byte first. Sits between the order/message logic and the UART/byte transmitter, with byte-level valid/ready backpressure.

---
 rtl/frame_packer.sv | 105 ++++++++++
 tb/tb_frame_packer.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_packer.sv
// Serialises one (type, payload) message into a byte frame: SOF, type byte, then
// PAYLOAD_LEN payload bytes MSB-first, with valid/ready backpressure on the byte side.
module frame_packer #(
  parameter int          PAYLOAD_LEN = 4,
  parameter logic [7:0]  SOF_BYTE    = 8'h7E
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [1:0]               msg_type,
  input  logic [PAYLOAD_LEN*8-1:0] msg_payload,
  input  logic                     msg_valid,
  output logic                     msg_ready,
  output logic [7:0]               tx_data,
  output logic                     tx_data_valid,
  input  logic                     tx_ready,
  output logic                     busy,
  output logic                     frame_done
);

  localparam int PW = PAYLOAD_LEN * 8;
  localparam int CW = $clog2(PAYLOAD_LEN) + 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(PAYLOAD_LEN - 1);

  typedef enum logic [2:0] {
    IDLE,
    SEND_SOF,
    SEND_TYPE,
    SEND_PAY,
    DONE
  } state_t;

  state_t        state;
  logic [1:0]    type_q;
  logic [PW-1:0] pay_q;
  logic [CW-1:0] cnt;
  logic          xfer;

  function automatic logic [7:0] head_byte(input logic [PW-1:0] p);
    return p[PW-1 -: 8];
  endfunction

  assign xfer      = tx_data_valid && tx_ready;
  assign msg_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  // Payload is held in a shift register so the next byte is always at the top.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      type_q        <= '0;
      pay_q         <= '0;
      cnt           <= '0;
      tx_data       <= 8'h00;
      tx_data_valid <= 1'b0;
      frame_done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt        <= '0;
          frame_done <= 1'b0;
          if (msg_valid) begin
            type_q        <= msg_type;
            pay_q         <= msg_payload;
            tx_data       <= SOF_BYTE;
            tx_data_valid <= 1'b1;
            state         <= SEND_SOF;
          end
        end
        SEND_SOF: begin
          if (xfer) begin
            tx_data <= {6'b0, type_q};
            state   <= SEND_TYPE;
          end
        end
        SEND_TYPE: begin
          if (xfer) begin
            tx_data <= head_byte(pay_q);
            pay_q   <= pay_q << 8;
            cnt     <= '0;
            state   <= SEND_PAY;
          end
        end
        SEND_PAY: begin
          if (xfer) begin
            if (cnt == LAST_IDX) begin
              tx_data_valid <= 1'b0;
              frame_done    <= 1'b1;
              state         <= DONE;
            end else begin
              cnt     <= cnt + CW'(1);
              tx_data <= head_byte(pay_q);
              pay_q   <= pay_q << 8;
            end
          end
        end
        DONE: begin
          frame_done <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_packer.sv
// Randomised self-checking bench for frame_packer: a message-level model predicts the
// byte stream, which is compared against bytes captured on every tx handshake.
module tb_frame_packer;
  localparam int L = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [1:0]    msg_type;
  logic [L*8-1:0] msg_payload;
  logic          msg_valid;
  logic          msg_ready;
  logic [7:0]    tx_data;
  logic          tx_data_valid;
  logic          tx_ready;
  logic          busy;
  logic          frame_done;

  logic [1:0] m1_type;
  logic [7:0] m1_pay;
  logic       m1_valid, m1_ready, m1_dvalid, m1_txr, m1_busy, m1_done;
  logic [7:0] m1_data;

  frame_packer #(.PAYLOAD_LEN(L), .SOF_BYTE(8'h7E)) dut (
    .clk(clk), .rst_n(rst_n), .msg_type(msg_type), .msg_payload(msg_payload),
    .msg_valid(msg_valid), .msg_ready(msg_ready), .tx_data(tx_data),
    .tx_data_valid(tx_data_valid), .tx_ready(tx_ready), .busy(busy),
    .frame_done(frame_done)
  );

  frame_packer #(.PAYLOAD_LEN(1), .SOF_BYTE(8'h7E)) dut1 (
    .clk(clk), .rst_n(rst_n), .msg_type(m1_type), .msg_payload(m1_pay),
    .msg_valid(m1_valid), .msg_ready(m1_ready), .tx_data(m1_data),
    .tx_data_valid(m1_dvalid), .tx_ready(m1_txr), .busy(m1_busy),
    .frame_done(m1_done)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  logic [7:0] obs[$];
  logic [7:0] exp[$];

  int   rdy_mode = 0;  // 0: always ready, 1: random, 2: manual
  logic manual_rdy = 1'b1;
  logic rand_rdy = 1'b1;

  always_comb begin
    tx_ready = 1'b1;
    if (rdy_mode == 1) tx_ready = rand_rdy;
    else if (rdy_mode == 2) tx_ready = manual_rdy;
  end

  always @(negedge clk) rand_rdy <= ($urandom_range(0, 3) != 0);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (tx_data_valid && tx_ready) obs.push_back(tx_data);
    if (frame_done) done_cnt <= done_cnt + 1;
  end

  // Presents a message, holds it until taken, records the expected frame bytes.
  task automatic send_msg(input logic [1:0] t, input logic [L*8-1:0] p, output int acc);
    msg_type = t;
    msg_payload = p;
    msg_valid = 1'b1;
    acc = -1;
    for (int i = 0; i < 300; i++) begin
      if (msg_ready) begin
        @(posedge clk);
        acc = cyc;
        break;
      end
      @(negedge clk);
    end
    if (acc >= 0) begin
      exp.push_back(8'h7E);
      exp.push_back({6'b0, t});
      for (int k = 0; k < L; k++) exp.push_back(p[(L-1-k)*8 +: 8]);
    end
    @(negedge clk);
    msg_valid = 1'b0;
    msg_payload = $urandom;
    msg_type = 2'($urandom);
  endtask

  task automatic wait_frames(input int target);
    for (int i = 0; i < 600 && done_cnt < target; i++) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got %h want 00", tx_data); end
    checks++; if (tx_data_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", tx_data_valid); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", frame_done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (msg_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", msg_ready); end
  endtask

  task automatic test_basic;
    int acc;
    rdy_mode = 0;
    obs.delete(); exp.delete();
    send_msg(2'b10, 32'hDEADBEEF, acc);
    checks++; if (acc < 0) begin errors++; $display("FAIL basic_accept got timeout want accept"); end
    for (int i = 0; i < L + 2; i++) begin
      checks++;
      if (tx_data_valid !== 1'b1 || tx_data !== exp[i])
        begin errors++; $display("FAIL basic_byte%0d got v=%b %h want v=1 %h", i, tx_data_valid, tx_data, exp[i]); end
      @(negedge clk);
    end
    checks++; if (frame_done !== 1'b1 || tx_data_valid !== 1'b0 || msg_ready !== 1'b0 || busy !== 1'b1)
      begin errors++; $display("FAIL basic_done got done=%b v=%b rdy=%b busy=%b want 1 0 0 1", frame_done, tx_data_valid, msg_ready, busy); end
    @(negedge clk);
    checks++; if (frame_done !== 1'b0 || msg_ready !== 1'b1 || busy !== 1'b0)
      begin errors++; $display("FAIL basic_idle got done=%b rdy=%b busy=%b want 0 1 0", frame_done, msg_ready, busy); end
  endtask

  task automatic test_backpressure;
    int acc, d0;
    bit found;
    rdy_mode = 2;
    manual_rdy = 1'b1;
    obs.delete(); exp.delete();
    d0 = done_cnt;
    found = 1'b0;
    send_msg(2'b10, 32'hDEADBEEF, acc);
    for (int i = 0; i < 10; i++) begin
      if (tx_data_valid && tx_data == 8'hAD) begin found = 1'b1; break; end
      @(negedge clk);
    end
    checks++; if (!found) begin errors++; $display("FAIL bp_find got no AD want AD presented"); end
    manual_rdy = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      checks++;
      if (tx_data_valid !== 1'b1 || tx_data !== 8'hAD)
        begin errors++; $display("FAIL bp_hold%0d got v=%b %h want v=1 ad", j, tx_data_valid, tx_data); end
    end
    manual_rdy = 1'b1;
    wait_frames(d0 + 1);
    checks++; if (done_cnt !== d0 + 1) begin errors++; $display("FAIL bp_done got %0d want %0d", done_cnt - d0, 1); end
    checks++; if (obs.size() != exp.size()) begin errors++; $display("FAIL bp_len got %0d want %0d", obs.size(), exp.size()); end
    for (int i = 0; i < obs.size() && i < exp.size(); i++) begin
      checks++; if (obs[i] !== exp[i]) begin errors++; $display("FAIL bp_byte%0d got %h want %h", i, obs[i], exp[i]); end
    end
    rdy_mode = 0;
  endtask

  task automatic test_busy_reject;
    int acc, d0;
    rdy_mode = 1;
    obs.delete(); exp.delete();
    d0 = done_cnt;
    send_msg(2'b01, 32'hCAFEF00D, acc);
    repeat (2) @(negedge clk);
    msg_type = 2'b11;
    msg_payload = 32'h11223344;
    msg_valid = 1'b1;
    checks++; if (msg_ready !== 1'b0) begin errors++; $display("FAIL busy_ready got %b want 0", msg_ready); end
    @(negedge clk);
    msg_valid = 1'b0;
    wait_frames(d0 + 1);
    repeat (3) @(negedge clk);
    checks++; if (done_cnt !== d0 + 1) begin errors++; $display("FAIL busy_done got %0d want 1", done_cnt - d0); end
    checks++; if (obs.size() != exp.size()) begin errors++; $display("FAIL busy_len got %0d want %0d", obs.size(), exp.size()); end
    for (int i = 0; i < obs.size() && i < exp.size(); i++) begin
      checks++; if (obs[i] !== exp[i]) begin errors++; $display("FAIL busy_byte%0d got %h want %h", i, obs[i], exp[i]); end
    end
    rdy_mode = 0;
  endtask

  task automatic test_back_to_back;
    int a0, a1, d0;
    rdy_mode = 0;
    obs.delete(); exp.delete();
    d0 = done_cnt;
    send_msg(2'b00, 32'h7E000000 | 32'($urandom_range(0, 65535)), a0);
    send_msg(2'b11, 32'h11223344, a1);
    wait_frames(d0 + 2);
    checks++; if (a1 - a0 != L + 4) begin errors++; $display("FAIL b2b_spacing got %0d want %0d", a1 - a0, L + 4); end
    checks++; if (obs.size() != exp.size()) begin errors++; $display("FAIL b2b_len got %0d want %0d", obs.size(), exp.size()); end
    for (int i = 0; i < obs.size() && i < exp.size(); i++) begin
      checks++; if (obs[i] !== exp[i]) begin errors++; $display("FAIL b2b_byte%0d got %h want %h", i, obs[i], exp[i]); end
    end
  endtask

  task automatic test_reset_mid;
    int acc, d0;
    rdy_mode = 0;
    obs.delete(); exp.delete();
    send_msg(2'b01, $urandom, acc);
    for (int i = 0; i < 20 && obs.size() < 2; i++) @(negedge clk);
    checks++; if (obs.size() != 2 || obs[0] !== 8'h7E || obs[1] !== 8'h01)
      begin errors++; $display("FAIL mid_prefix got n=%0d want 7e,01 sent", obs.size()); end
    rst_n = 1'b0;
    #1;
    checks++; if (tx_data_valid !== 1'b0 || tx_data !== 8'h00 || busy !== 1'b0 || frame_done !== 1'b0)
      begin errors++; $display("FAIL mid_reset got v=%b d=%h busy=%b done=%b want 0 00 0 0", tx_data_valid, tx_data, busy, frame_done); end
    @(negedge clk);
    rst_n = 1'b1;
    obs.delete(); exp.delete();
    repeat (3) @(negedge clk);
    checks++; if (obs.size() != 0 || tx_data_valid !== 1'b0)
      begin errors++; $display("FAIL mid_abandon got n=%0d v=%b want 0 0", obs.size(), tx_data_valid); end
    d0 = done_cnt;
    send_msg(2'b01, 32'h7E7E0001, acc);
    wait_frames(d0 + 1);
    checks++; if (done_cnt !== d0 + 1) begin errors++; $display("FAIL mid_done got %0d want 1", done_cnt - d0); end
    checks++; if (obs.size() != exp.size()) begin errors++; $display("FAIL mid_len got %0d want %0d", obs.size(), exp.size()); end
    for (int i = 0; i < obs.size() && i < exp.size(); i++) begin
      checks++; if (obs[i] !== exp[i]) begin errors++; $display("FAIL mid_byte%0d got %h want %h", i, obs[i], exp[i]); end
    end
  endtask

  task automatic test_loopback;
    int acc, d0, n_acc, base;
    logic [1:0]     st[20];
    logic [L*8-1:0] sp[20];
    logic [L*8-1:0] rp;
    rdy_mode = 1;
    obs.delete(); exp.delete();
    d0 = done_cnt;
    n_acc = 0;
    for (int k = 0; k < 20; k++) begin
      st[k] = 2'($urandom);
      sp[k] = (k == 3) ? 32'h7E7E7E7E : $urandom;
      send_msg(st[k], sp[k], acc);
      if (acc >= 0) n_acc++;
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    wait_frames(d0 + 20);
    checks++; if (n_acc != 20) begin errors++; $display("FAIL loop_accepts got %0d want 20", n_acc); end
    checks++; if (done_cnt - d0 != 20) begin errors++; $display("FAIL loop_done got %0d want 20", done_cnt - d0); end
    checks++; if (obs.size() != 20 * (L + 2)) begin errors++; $display("FAIL loop_len got %0d want %0d", obs.size(), 20 * (L + 2)); end
    // Receiver view: rebuild each message from the captured byte stream.
    for (int k = 0; k < 20 && (k + 1) * (L + 2) <= obs.size(); k++) begin
      base = k * (L + 2);
      rp = '0;
      for (int b = 0; b < L; b++) rp = (rp << 8) | (L*8)'(obs[base + 2 + b]);
      checks++;
      if (obs[base] !== 8'h7E || obs[base + 1] !== {6'b0, st[k]} || rp !== sp[k])
        begin errors++; $display("FAIL loop_msg%0d got sof=%h type=%h pay=%h want 7e %h %h", k, obs[base], obs[base + 1], rp, {6'b0, st[k]}, sp[k]); end
    end
    rdy_mode = 0;
  endtask

  task automatic test_len1;
    logic [7:0] e1[3] = '{8'h7E, 8'h03, 8'hA5};
    m1_txr = 1'b1;
    m1_type = 2'b11;
    m1_pay = 8'hA5;
    m1_valid = 1'b1;
    checks++; if (m1_ready !== 1'b1) begin errors++; $display("FAIL len1_ready got %b want 1", m1_ready); end
    @(posedge clk);
    @(negedge clk);
    m1_valid = 1'b0;
    m1_pay = 8'h00;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (m1_dvalid !== 1'b1 || m1_data !== e1[i])
        begin errors++; $display("FAIL len1_byte%0d got v=%b %h want v=1 %h", i, m1_dvalid, m1_data, e1[i]); end
      @(negedge clk);
    end
    checks++; if (m1_done !== 1'b1 || m1_dvalid !== 1'b0) begin errors++; $display("FAIL len1_done got done=%b v=%b want 1 0", m1_done, m1_dvalid); end
    @(negedge clk);
    checks++; if (m1_done !== 1'b0 || m1_ready !== 1'b1) begin errors++; $display("FAIL len1_idle got done=%b rdy=%b want 0 1", m1_done, m1_ready); end
  endtask

  initial begin
    rst_n = 1'b0;
    msg_valid = 1'b0;
    msg_type = 2'b00;
    msg_payload = '0;
    m1_valid = 1'b0;
    m1_type = 2'b00;
    m1_pay = 8'h00;
    m1_txr = 1'b1;
    @(negedge clk);
    test_reset;
    test_basic;
    test_backpressure;
    test_busy_reject;
    test_back_to_back;
    test_reset_mid;
    test_loopback;
    test_len1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
